inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage that consumes the next-PC/branch-target side of the PC logic. Holds the architectural fetch PC and issues in-order 32-bit instruction reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small queue and presents them to decode with valid/ready, tagged with their PC.
- Accepts redirects from branch resolution: flushes the queue and discards any in-flight responses.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded on reset; must be 4-byte aligned.
- QUEUE_DEPTH, 2, instruction queue entries; also the cap on (queued + outstanding) fetches; legal range 1..8.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst_n  input  1  asynchronous active-low reset.
- RedirectValid  input  1  redirect fetch to RedirectPC this cycle.
- RedirectPC  input  64  new fetch PC; bits [1:0] ignored and treated as 0.
- ImemReqValid  output  1  read request valid.
- ImemReqReady  input  1  memory accepts the request.
- ImemAddr  output  64  request byte address; always 4-byte aligned.
- ImemRespValid  input  1  read data returned; one response per accepted request, in order, at least 1 cycle after acceptance.
- ImemRespData  input  32  instruction word.
- InstValid  output  1  queue head valid to decode.
- InstReady  input  1  decode accepts the head.
- Inst  output  32  head instruction.
- InstPC  output  64  PC of the head instruction.

Behaviour:
- Reset (async assert, sync release):
  - FetchPC = RESET_PC; queue empty; Outstanding = 0; DropCnt = 0.
  - ImemReqValid = 0, ImemAddr = RESET_PC, InstValid = 0, Inst = 0, InstPC = 0.
- Credit rule:
  - A new request may start only when count + Outstanding < QUEUE_DEPTH, no request is pending, and RedirectValid = 0.
  - A new request drives ImemReqValid = 1 with ImemAddr = FetchPC.
- Request hold:
  - Once asserted, ImemReqValid and ImemAddr are held stable until ImemReqReady, including across a redirect.
  - On acceptance: FetchPC += 4 (mod 2^64) and Outstanding += 1.
  - Back-to-back requests are allowed when credit permits, at 1 request/cycle maximum.
- Response path:
  - On ImemRespValid with DropCnt > 0: DropCnt -= 1, Outstanding -= 1, word discarded.
  - Otherwise: push {ImemRespData, PC of that request} into the queue and Outstanding -= 1. The request PC is tracked in a PC FIFO or derived from the queue-tail PC plus 4.
  - Credit guarantees the queue never overflows. A response arriving with Outstanding = 0 is a protocol violation; flag it with a simulation assertion only.
- Decode handshake:
  - InstValid = queue non-empty AND !RedirectValid. The gating on RedirectValid is combinational.
  - Pop when InstValid && InstReady. Inst/InstPC are stable while InstValid && !InstReady.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- Redirect (RedirectValid = 1 in cycle T):
  - At the T edge: queue cleared, FetchPC = {RedirectPC[63:2], 2'b00}, DropCnt = Outstanding_after_T.
  - Outstanding_after_T counts requests accepted at T and excludes responses already consumed at T. A response arriving in T is dropped.
  - A request pending unaccepted at T stays on the bus. Its acceptance increments both Outstanding and DropCnt, and FetchPC is not advanced by it.
  - The first request to the new PC issues no earlier than T+1.
  - Back-to-back redirects: the last one wins; each recomputes DropCnt consistently.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory transactions are the memory's responsibility.
- Widths:
  - Outstanding and DropCnt are $clog2(QUEUE_DEPTH+1) bits.
  - PC arithmetic is unsigned 64-bit wrap-around (FFFF_FFFF_FFFF_FFFC + 4 -> 0).

Test Plan:
- Reset RESET_PC=0x100, memory always ready, 1-cycle latency, decode always ready -> requests to 0x100, 0x104, 0x108…; InstPC follows the same sequence; steady-state throughput ≥ 1 instruction per 2 cycles with QUEUE_DEPTH=2.
- InstReady=0 for 10 cycles -> exactly 2 requests issued, queue full, ImemReqValid=0; on InstReady=1, 0x100 then 0x104 are delivered in order, then fetch resumes at 0x108.
- Two requests outstanding (0x200, 0x204), RedirectValid with RedirectPC=0x403 -> both responses dropped, next request addr=0x400, first delivered InstPC=0x400, InstValid=0 during the redirect cycle.
- ImemReqReady=0 holds a request to 0x300 while a redirect to 0x800 arrives -> ImemAddr stays 0x300 until accepted, its response is dropped, the next request is 0x800.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC -> requests 0x…FFFC then 0x0.
- Assert Rst_n=0 asynchronously mid-burst -> all outputs go to reset values without a clock edge; after release, fetch restarts at RESET_PC with no stale instruction delivered.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage.
//   Holds the fetch PC, issues in-order 32-bit reads over a valid/ready request
//   channel, buffers returned words in a small queue, and hands them to decode
//   tagged with their PC. A redirect flushes the queue and discards responses
//   still in flight.
// Ports:
//   Clk, Rst_n                   clock, async active-low reset
//   RedirectValid, RedirectPC    redirect fetch (low two PC bits ignored)
//   ImemReqValid/Ready, ImemAddr instruction memory request channel
//   ImemRespValid, ImemRespData  in-order response channel
//   InstValid/Ready, Inst, InstPC decode-side queue head
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RedirectValid,
  input  logic [63:0] RedirectPC,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [63:0] ImemAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Inst,
  output logic [63:0] InstPC
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [63:0]      req_addr_q, req_addr_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             stale_q, stale_d;     // pending request predates a redirect
  logic [63:0]      resp_pc_q, resp_pc_d; // PC of the next response to be kept
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      q_inst_q [QUEUE_DEPTH];
  logic [31:0]      q_inst_d [QUEUE_DEPTH];
  logic [63:0]      q_pc_q   [QUEUE_DEPTH];
  logic [63:0]      q_pc_d   [QUEUE_DEPTH];

  logic             accept, drop_resp, push, pop, inst_valid, start;
  logic [CNT_W+1:0] committed;
  logic [63:0]      fetch_pc_adv, redirect_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    redirect_pc = RedirectPC & ~64'd3;
    accept      = req_valid_q && ImemReqReady;
    drop_resp   = ImemRespValid && (drop_q != '0);
    push        = ImemRespValid && (drop_q == '0) && !RedirectValid;
    inst_valid  = (count_q != '0) && !RedirectValid;
    pop         = inst_valid && InstReady;

    // Pending request holds a credit; a request accepted this cycle may be
    // replaced immediately, giving back-to-back issue.
    committed = (CNT_W+2)'(count_q) + (CNT_W+2)'(outst_q) + (CNT_W+2)'(req_valid_q);
    start     = !RedirectValid && (!req_valid_q || ImemReqReady) &&
                (committed < (CNT_W+2)'(QUEUE_DEPTH));

    // A stale request (issued before a redirect) never advances the PC.
    fetch_pc_adv = (accept && !stale_q) ? fetch_pc_q + 64'd4 : fetch_pc_q;

    fetch_pc_d  = fetch_pc_adv;
    req_valid_d = start || (req_valid_q && !ImemReqReady);
    req_addr_d  = start ? fetch_pc_adv : req_addr_q;
    outst_d     = outst_q + CNT_W'(accept) - CNT_W'(ImemRespValid);
    drop_d      = drop_q + CNT_W'(accept && stale_q) - CNT_W'(drop_resp);
    stale_d     = stale_q && !accept;
    resp_pc_d   = push ? resp_pc_q + 64'd4 : resp_pc_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d      = pop ? ptr_inc(head_q) : head_q;
    tail_d      = push ? ptr_inc(tail_q) : tail_q;
    q_inst_d    = q_inst_q;
    q_pc_d      = q_pc_q;
    if (push) begin
      q_inst_d[tail_q] = ImemRespData;
      q_pc_d[tail_q]   = resp_pc_q;
    end

    // Everything still owed by memory after this edge gets discarded,
    // including a request accepted on this very edge.
    if (RedirectValid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = outst_d;
      stale_d    = req_valid_q && !accept;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      stale_q     <= 1'b0;
      resp_pc_q   <= RESET_PC;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      stale_q     <= stale_d;
      resp_pc_q   <= resp_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      q_inst_q    <= q_inst_d;
      q_pc_q      <= q_pc_d;
    end
  end

  assign ImemReqValid = req_valid_q;
  assign ImemAddr     = req_addr_q;
  assign InstValid    = inst_valid;
  assign Inst         = q_inst_q[head_q];
  assign InstPC       = q_pc_q[head_q];

  // A response with nothing outstanding is a memory protocol violation.
  resp_without_request: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(ImemRespValid && (outst_q == '0)));

endmodule
